cam_frame_fetch: RTL
====================

Name: cam_frame_fetch

Overview:
Bus-master copy engine directly downstream of the camera peripheral's downsampled framebuffer.
- On a start pulse, reads every 8-bit pixel of the WIDTH x HEIGHT frame through the camera peripheral's picorv32-style slave port.
- Packs 4 pixels per 32-bit word and writes the words sequentially into a destination word memory (MARLANN input buffer).
- Provides a per-access bus timeout with an error flag, so a hung slave cannot stall the engine.

Parameters:
WIDTH, 64, pixels per row; power of 2, >= 4.
HEIGHT, 32, rows per frame; power of 2.
FB_BASE, 16'h8000, slave byte address of pixel (0,0).
TIMEOUT, 255, maximum cycles to wait for cam_ready on one access; minimum 2.
DST_AW, 9, destination word-address width; must equal log2(WIDTH*HEIGHT/4).

Ports:
sys_clk  in  1  single clock, same as the camera peripheral's sys_clk.
areset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a frame copy when idle.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle pulse when a copy finishes, whether it completes or aborts.
error  out  1  sticky timeout flag; cleared by the next accepted start.
cam_valid  out  1  bus request to the camera peripheral.
cam_addr  out  16  byte address, FB_BASE + 4*(WIDTH*y + x).
cam_ready  in  1  slave ready; registered, so it follows cam_valid by one cycle.
cam_rdata  in  32  read data; the pixel is in bits 7..0.
dst_we  out  1  destination write strobe, one cycle per word.
dst_addr  out  DST_AW  destination word address.
dst_wdata  out  32  packed word: pixel x+k in byte k (k = 0..3, little-endian).

Behaviour:
- Reset (async, active-high): state IDLE; busy, done, error, cam_valid and dst_we = 0; cam_addr = FB_BASE; dst_addr = 0; dst_wdata = 0; pixel index = 0.
- States: IDLE, REQ, GAP, FIN.
- IDLE:
  - On start: clear error, zero the pixel index, enter REQ.
  - cam_addr is driven from the pixel index; cam_valid rises on entry to REQ.
- REQ:
  - cam_valid = 1; the wait counter increments each cycle.
  - On cam_ready = 1: capture cam_rdata[7:0] into byte lane (index mod 4) of the pack register, drop cam_valid on the same edge, enter GAP.
  - If the wait counter reaches TIMEOUT without cam_ready: drop cam_valid, set error, enter FIN. No partial word is written.
- GAP:
  - Exactly one cycle with cam_valid = 0; cam_ready is ignored here, because the slave's registered ready can echo for one extra cycle.
  - If the byte captured in REQ was lane 3: dst_we = 1 this cycle, with dst_wdata = the pack register and dst_addr = index/4.
  - Then increment the index. If the index wraps to 0 (WIDTH*HEIGHT pixels done), enter FIN; otherwise enter REQ.
- FIN: done = 1 for one cycle, busy drops, return to IDLE.
- Nominal throughput is 3 cycles per pixel (REQ 2, GAP 1); a full 64x32 frame takes 6144 cycles from first cam_valid to FIN.
- Address arithmetic:
  - The index is log2(WIDTH*HEIGHT) bits and wraps naturally.
  - cam_addr = FB_BASE + {index, 2'b00}, truncated to 16 bits.
  - x = index[log2 WIDTH-1:0]; y = upper bits.
- start while busy is ignored; the copy in progress is unaffected.
- start in the same cycle as FIN is ignored; the engine must see start in IDLE.
- Reset mid-copy aborts immediately: all outputs return to reset values, and the destination keeps whatever was already written.

Optional Feature:
CAM_FRAME_FETCH_SIGNED_EN
- Defined: each captured pixel is XORed with 8'h80 before packing, converting unsigned 0..255 into two's-complement pixel-128 for the signed MARLANN datapath.
- Undefined: bytes are passed through unchanged.

Decomposition:
- Package cam_frame_fetch_pkg holds:
  - the state enum (IDLE, REQ, GAP, FIN);
  - localparams for the default FB_BASE, WIDTH, HEIGHT and TIMEOUT;
  - the function computing the index width from WIDTH*HEIGHT.
- One natural sub-module, cam_px_pack:
  - 4-byte shift/pack register with lane select, optional signed conversion and a word-ready flag;
  - the FSM and bus timing stay in the top.

Test Plan:
1. Slave model returns pixel = (x + 3*y) & 8'hFF; pulse start -> 512 dst_we pulses, dst_addr 0..511; word 0 = 32'h03020100; word 16 (y=1, x=0..3) = 32'h06050403; done 1 cycle after the last GAP; total 6144+ cycles.
2. Slave holds ready high for one extra cycle after valid drops (echo) -> still exactly 2048 reads and 512 writes, with no duplicated or skipped pixel.
3. Slave never asserts ready at pixel index 5, TIMEOUT=255 -> cam_valid drops after 255 REQ cycles; error=1; done pulse; dst_we seen exactly once (word 0), never for word 1.
4. Pulse start at cycle 100 of an active copy -> ignored, data identical to scenario 1; then start from IDLE after an error -> error cleared on acceptance.
5. Assert areset during pixel 700 -> busy, cam_valid and dst_we = 0 asynchronously; a later start copies from index 0 correctly.
6. With CAM_FRAME_FETCH_SIGNED_EN, pixels 8'h00, 8'h80, 8'hFF, 8'h7F at x=0..3 -> word 0 = 32'hFF7F0080.

Source files
------------

// File: rtl/cam_frame_fetch_pkg.sv
// Shared types and defaults for the camera frame fetch engine.
// Optional feature macro: CAM_FRAME_FETCH_SIGNED_EN (see cam_px_pack).
package cam_frame_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int          DEF_WIDTH   = 64;
    localparam int          DEF_HEIGHT  = 32;
    localparam int          DEF_TIMEOUT = 255;
    localparam logic [15:0] DEF_FB_BASE = 16'h8000;

    // Four 8-bit pixels per destination word.
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;

    // Pixel index width; the index wraps to 0 after the last pixel.
    function automatic int idx_width(input int width, input int height);
        return $clog2(width * height);
    endfunction

endpackage

// File: rtl/cam_px_pack.sv
// Byte-lane pack register: collects four pixels into one 32-bit word.
// With CAM_FRAME_FETCH_SIGNED_EN defined, each pixel has its MSB flipped
// (unsigned 0..255 -> two's-complement pixel-128) before packing.
module cam_px_pack
    import cam_frame_fetch_pkg::*;
(
    input  logic                              sys_clk,
    input  logic                              areset,
    input  logic                              load,
    input  logic [$clog2(NUM_LANES)-1:0]      lane,
    input  logic [VEC_W-1:0]                  pixel,
    output logic [NUM_LANES*VEC_W-1:0]        word,
    output logic                              word_rdy
);

    logic [NUM_LANES-1:0][VEC_W-1:0] lanes;
    logic [VEC_W-1:0]                px_conv;

`ifdef CAM_FRAME_FETCH_SIGNED_EN
    assign px_conv = pixel ^ {1'b1, {(VEC_W-1){1'b0}}};
`else
    assign px_conv = pixel;
`endif

    // Write the incoming pixel into its selected byte lane.
    always_ff @(posedge sys_clk or posedge areset) begin
        if (areset) begin
            lanes <= '0;
        end else if (load) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (lane == $clog2(NUM_LANES)'(i)) lanes[i] <= px_conv;
            end
        end
    end

    // Word is complete the cycle after the top lane is loaded.
    always_ff @(posedge sys_clk or posedge areset) begin
        if (areset) word_rdy <= 1'b0;
        else        word_rdy <= load && (lane == $clog2(NUM_LANES)'(NUM_LANES-1));
    end

    assign word = lanes;

endmodule

// File: rtl/cam_frame_fetch.sv
// Bus-master copy engine: reads a WIDTH x HEIGHT 8-bit frame from the camera
// slave port one pixel at a time and writes packed 32-bit words into a
// destination word memory. Each access is bounded by TIMEOUT cycles.
// Optional feature macro: CAM_FRAME_FETCH_SIGNED_EN (signed pixel packing).
module cam_frame_fetch
    import cam_frame_fetch_pkg::*;
#(
    parameter int          WIDTH   = DEF_WIDTH,
    parameter int          HEIGHT  = DEF_HEIGHT,
    parameter logic [15:0] FB_BASE = DEF_FB_BASE,
    parameter int          TIMEOUT = DEF_TIMEOUT,
    parameter int          DST_AW  = 9
)(
    input  logic              sys_clk,
    input  logic              areset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cam_valid,
    output logic [15:0]       cam_addr,
    input  logic              cam_ready,
    input  logic [31:0]       cam_rdata,
    output logic              dst_we,
    output logic [DST_AW-1:0] dst_addr,
    output logic [31:0]       dst_wdata
);

    localparam int IW = idx_width(WIDTH, HEIGHT);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  idx_nxt;
    logic [TW-1:0]  wait_cnt;
    logic [15:0]    addr_off;
    logic           pk_load;
    logic [23:0]    rdata_unused;

    assign idx_nxt  = idx + 1'b1;
    assign addr_off = 16'({idx_nxt, 2'b00});
    // Capture only in REQ; a ready echo during GAP must not load a pixel.
    assign pk_load  = (state == REQ) && cam_ready;
    assign rdata_unused = cam_rdata[31:8];

    cam_px_pack u_pack (
        .sys_clk  (sys_clk),
        .areset   (areset),
        .load     (pk_load),
        .lane     (idx[1:0]),
        .pixel    (cam_rdata[7:0]),
        .word     (dst_wdata),
        .word_rdy (dst_we)
    );

    // Copy sequencer: REQ waits for ready (bounded), GAP retires the pixel.
    always_ff @(posedge sys_clk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cam_valid <= 1'b0;
            cam_addr  <= FB_BASE;
            dst_addr  <= '0;
            idx       <= '0;
            wait_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        error     <= 1'b0;
                        idx       <= '0;
                        cam_addr  <= FB_BASE;
                        cam_valid <= 1'b1;
                        busy      <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (cam_ready) begin
                        cam_valid <= 1'b0;
                        dst_addr  <= DST_AW'(idx >> 2);
                        state     <= GAP;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        // Hung slave: abandon the frame, partial word is dropped.
                        cam_valid <= 1'b0;
                        error     <= 1'b1;
                        done      <= 1'b1;
                        state     <= FIN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                GAP: begin
                    idx <= idx_nxt;
                    if (idx_nxt == '0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        cam_addr  <= FB_BASE + addr_off;
                        cam_valid <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= REQ;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
